// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared widths and types for the instruction-fetch path.
// Fetch packets carry the byte PC alongside the word so decode never has to
// reconstruct it.
package imem_fetch_ctrl_pkg;

  localparam int IMEM_ADDR_WIDTH = 16;
  localparam int IMEM_DATA_WIDTH = 32;
  localparam int IMEM_INST_BYTES = IMEM_DATA_WIDTH / 8;

  typedef logic [IMEM_ADDR_WIDTH-1:0] imem_addr_t;
  typedef logic [IMEM_DATA_WIDTH-1:0] imem_data_t;

  typedef struct packed {
    imem_addr_t pc;
    imem_data_t inst;
  } fetch_pkt_t;

  // Word-aligns a byte address (low two bits dropped).
  function automatic imem_addr_t word_align(imem_addr_t a);
    return a & ~imem_addr_t'(3);
  endfunction

endpackage

// File: rtl/imem_if.sv
// Instruction memory port: ena/addr issued by the fetch controller, dout
// returned by the memory one cycle later (synchronous read).
interface imem_if;

  logic                                       ena;
  logic [imem_fetch_ctrl_pkg::IMEM_ADDR_WIDTH-1:0] addr;
  logic [imem_fetch_ctrl_pkg::IMEM_DATA_WIDTH-1:0] dout;

  modport ctrl_port (output ena, output addr, input dout);
  modport mem_port  (input ena, input addr, output dout);

endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch packets.
// Flush wins over push/pop. Any DEPTH >= 2 works (pointers wrap explicitly,
// so DEPTH need not be a power of two). Storage is reset so the head reads
// zero out of reset.
module fetch_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_pkt_t                 din,
  output fetch_pkt_t                 dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_pkt_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // The fetch credit scheme must never deliver a word into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, issues one-word reads to imem, buffers returned words in
// fetch_fifo and presents {pc, inst} to decode over valid/ready.
// Redirects flush everything buffered or in flight and reload the PC.
// Optional: define IFETCH_PERF_EN to add perf_issue_cnt / perf_stall_cnt.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                         FIFO_DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  imem_if.ctrl_port                  imem,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [IMEM_ADDR_WIDTH-1:0] inst_pc,
  output logic [IMEM_DATA_WIDTH-1:0] inst,
`ifdef IFETCH_PERF_EN
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt,
`endif
  output logic                       busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} fetch_state_e;

  fetch_state_e state_q, state_d;
  imem_addr_t   pc_q;
  imem_addr_t   inflight_pc_q;
  logic         inflight_q;

  logic         issue, room, pop, push, empty;
  logic [CW-1:0] occ;
  fetch_pkt_t   push_pkt, head_pkt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: fetch_en starts/stops issue; redirect never changes state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch_en)  state_d = S_FETCH;
      S_FETCH: if (!fetch_en) state_d = S_HALT;
      S_HALT:  if (fetch_en)  state_d = S_FETCH;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs: issue only when the FIFO is guaranteed a slot for the word,
  // counting the in-flight word and crediting this cycle's pop.
  // A redirect suppresses issue and hides the FIFO head in the same cycle.
  always_comb begin
    inst_valid = !empty && !redirect_valid;
    pop        = inst_valid && inst_ready;
    room       = (int'(occ) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
    issue      = (state_q == S_FETCH) && !redirect_valid && room;
    push       = inflight_q && !redirect_valid;
    imem.ena   = issue;
    imem.addr  = issue ? pc_q : '0;
  end

  // PC and in-flight tracking; redirect flushes the outstanding word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q          <= word_align(redirect_pc);
      inflight_q    <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + IMEM_ADDR_WIDTH'(IMEM_INST_BYTES);
        inflight_pc_q <= pc_q;
      end
    end
  end

  assign push_pkt = '{pc: inflight_pc_q, inst: imem.dout};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_pkt),
    .dout  (head_pkt),
    .empty (empty),
    .count (occ)
  );

  assign inst_pc = head_pkt.pc;
  assign inst    = head_pkt.inst;
  assign busy    = !empty || inflight_q;

`ifdef IFETCH_PERF_EN
  // Free-running event counters; wrap naturally, untouched by redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue)                    perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (inst_valid && !inst_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
